// File: rtl/pulse_scheduler.sv
// pulse_scheduler: one shared pulse timer, round-robin arbitrated among NCH channels.
// Ports: clk/reset (async, active-high), enable, req/sel_long in; busy, pulse_out, grant, pulse_ch, done, count out.
module pulse_scheduler #(
    parameter int NCH       = 4,
    parameter int CHW       = 2,
    parameter int CW        = 8,
    parameter int SHORT_LEN = 5,
    parameter int LONG_LEN  = 20,
    parameter int GAP_LEN   = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] sel_long,
    output logic           busy,
    output logic           pulse_out,
    output logic [NCH-1:0] grant,
    output logic [CHW-1:0] pulse_ch,
    output logic [NCH-1:0] done,
    output logic [CW-1:0]  count
);

    if (NCH < 2 || NCH > 8) begin : g_bad_nch
        $error("pulse_scheduler: NCH out of range");
    end
    if (CHW != $clog2(NCH)) begin : g_bad_chw
        $error("pulse_scheduler: CHW must equal clog2(NCH)");
    end
    if (SHORT_LEN < 1 || SHORT_LEN > (2**CW) - 1) begin : g_bad_short
        $error("pulse_scheduler: SHORT_LEN out of range");
    end
    if (LONG_LEN < 1 || LONG_LEN > (2**CW) - 1) begin : g_bad_long
        $error("pulse_scheduler: LONG_LEN out of range");
    end
    if (GAP_LEN < 0 || GAP_LEN > (2**CW) - 1) begin : g_bad_gap
        $error("pulse_scheduler: GAP_LEN out of range");
    end

    localparam logic [CW-1:0] SLEN  = CW'(SHORT_LEN);
    localparam logic [CW-1:0] LLEN  = CW'(LONG_LEN);
    localparam logic [CW-1:0] GLAST = CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  len_q, len_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic [CHW-1:0] last_q, last_d;

    logic           win_found;
    logic [CHW-1:0] win_idx;
    logic [CHW-1:0] scan_idx;

    // Rotating priority: scan upward starting just after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 1; i <= NCH; i++) begin
            scan_idx = CHW'((int'(last_q) + i) % NCH);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        len_d     = len_q;
        ch_d      = ch_q;
        last_d    = last_q;
        busy      = 1'b0;
        pulse_out = 1'b0;
        grant     = '0;
        done      = '0;
        unique case (state_q)
            S_IDLE: begin
                if (enable && win_found) begin
                    state_d = S_ACTIVE;
                    ch_d    = win_idx;
                    last_d  = win_idx;
                    len_d   = sel_long[win_idx] ? LLEN : SLEN;
                    count_d = '0;
                end
            end
            S_ACTIVE: begin
                busy         = 1'b1;
                pulse_out    = 1'b1;
                grant[ch_q]  = 1'b1;
                if (count_q == len_q - 1'b1) begin
                    done[ch_q] = 1'b1;
                    count_d    = '0;
                    state_d    = (GAP_LEN > 0) ? S_GAP : S_IDLE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            S_GAP: begin
                busy = 1'b1;
                if (count_q == GLAST) begin
                    count_d = '0;
                    state_d = S_IDLE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            len_q   <= SLEN;
            ch_q    <= '0;
            last_q  <= CHW'(NCH - 1);
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
        end
    end

    assign pulse_ch = ch_q;
    assign count    = count_q;

endmodule
